adc_spi_cfg: RTL

Parametrised ADC configuration controller, the next generation of the ADC board interface. It exposes an Avalon-MM register slave to the soft processor and runs 3-wire SPI transactions to the ADC serial configuration port, with full read-back over a shared SDIO line. It also holds NUM_CH per-channel gain codes that drive the front-end pin straps. It sits between the Avalon fabric and the top-level ADC pins; the SDIO tristate buffer lives at the top level.

---
 rtl/adc_spi_cfg.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_spi_cfg.sv
// ADC configuration controller: Avalon-MM register slave driving 3-wire SPI
// transactions (24-bit frames, shared SDIO with read-back) plus per-channel gain straps.
module adc_spi_cfg #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned GAIN_W  = 3
) (
    input  logic                     main_clk,
    input  logic                     reset_n,
    input  logic [3:0]               address,
    input  logic                     write,
    input  logic                     read,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic                     ADC_CSBn,
    output logic                     ADC_SCLK,
    output logic                     sdio_out,
    output logic                     sdio_oe,
    input  logic                     sdio_in,
    output logic [NUM_CH*GAIN_W-1:0] ch_gain
);

    localparam int unsigned    DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    // Bits of the 13-bit instruction address field that are backed by storage
    localparam logic [12:0]    AddrMask = 13'((32'd1 << ADDR_W) - 32'd1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q;
    logic [4:0]          fall_q;      // SCLK falling edges seen in this frame
    logic                sclk_q;
    logic                oe_q;
    logic                rnw_q;
    logic                done_q;
    logic [23:0]         shreg_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [12:0]         spi_addr_q;
    logic [DATA_W-1:0]   readdata_q;
    logic [DATA_W-1:0]   rd_mux;
    logic [GAIN_W-1:0]   gain_q [NUM_CH];

    logic div_end, busy, start, start_rd;

    assign div_end  = (div_q == DivLast);
    assign busy     = (state_q != StIdle);
    assign start    = write && (address == 4'd3) && !busy && (writedata[0] || writedata[1]);
    // Write wins when both start bits are set
    assign start_rd = !writedata[0];

    // FSM state register
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: if (div_end) state_d = StShift;
            // Leave after the low half of the 24th SCLK period has elapsed
            StShift: if (div_end && !sclk_q && (fall_q == 5'd24)) state_d = StHold;
            StHold:  if (div_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        ADC_CSBn = (state_q == StIdle);
        ADC_SCLK = sclk_q;
        sdio_oe  = oe_q;
        sdio_out = oe_q & shreg_q[23];
    end

    // Frame datapath: divider, SCLK, shift-out, read-back sampling, status
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            div_q   <= '0;
            fall_q  <= '0;
            sclk_q  <= 1'b0;
            oe_q    <= 1'b0;
            rnw_q   <= 1'b0;
            done_q  <= 1'b0;
            shreg_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    div_q  <= '0;
                    fall_q <= '0;
                    sclk_q <= 1'b0;
                    if (start) begin
                        shreg_q <= {start_rd, 2'b00, spi_addr_q, wdata_q};
                        rnw_q   <= start_rd;
                        oe_q    <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StSetup: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) sclk_q <= 1'b1;
                end
                StShift: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        if (sclk_q) begin
                            // Falling edge: present the next bit
                            sclk_q  <= 1'b0;
                            shreg_q <= {shreg_q[22:0], 1'b0};
                            fall_q  <= fall_q + 1'b1;
                            // Hand SDIO to the ADC after the 16th falling edge
                            if (rnw_q && (fall_q == 5'd15)) oe_q <= 1'b0;
                        end else if (fall_q != 5'd24) begin
                            sclk_q <= 1'b1;
                            // Rising edges 17..24 carry the read data byte
                            if (rnw_q && (fall_q >= 5'd16)) rx_q <= {rx_q[DATA_W-2:0], sdio_in};
                        end
                    end
                end
                StHold: begin
                    div_q <= div_end ? '0 : div_q + 1'b1;
                    if (div_end) begin
                        oe_q   <= 1'b0;
                        done_q <= 1'b1;
                        if (rnw_q) rdata_q <= rx_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // SPI address and write-data registers, frozen while a frame is in flight
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            spi_addr_q <= '0;
            wdata_q    <= '0;
        end else if (write && !busy) begin
            case (address)
                4'd0: spi_addr_q <= {spi_addr_q[12:8], writedata[7:0]} & AddrMask;
                4'd1: spi_addr_q <= {writedata[4:0], spi_addr_q[7:0]} & AddrMask;
                4'd2: wdata_q    <= writedata;
                default: ;
            endcase
        end
    end

    // Gain code registers, writable at any time
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NUM_CH); k++) gain_q[k] <= '0;
        end else if (write) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (address == 4'(5 + k)) gain_q[k] <= writedata[GAIN_W-1:0];
            end
        end
    end

    // Read mux
    always_comb begin
        rd_mux = '0;
        case (address)
            4'd0: rd_mux = DATA_W'(spi_addr_q[7:0]);
            4'd1: rd_mux = DATA_W'(spi_addr_q[12:8]);
            4'd2: rd_mux = wdata_q;
            4'd3: rd_mux = DATA_W'({busy, done_q});
            4'd4: rd_mux = rdata_q;
            default: begin
                for (int k = 0; k < int'(NUM_CH); k++) begin
                    if (address == 4'(5 + k)) rd_mux = DATA_W'(gain_q[k]);
                end
            end
        endcase
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge main_clk) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (read) begin
            readdata_q <= rd_mux;
        end
    end

    assign readdata = readdata_q;

    // Pack gain codes onto the strap bus
    always_comb begin
        ch_gain = '0;
        for (int k = 0; k < int'(NUM_CH); k++) ch_gain[k*GAIN_W +: GAIN_W] = gain_q[k];
    end

endmodule
